// File: rtl/seq_multiplier_if.sv
// Handshake and data bundle for the sequential multiplier.
// The master drives requests (start, operands, mode) and the slave returns
// status and the result.
interface seq_multiplier_if #(
   parameter int WIDTH = 8
);
   logic                 start;
   logic                 signed_mode;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output start, signed_mode, a, b,
      input  busy, done, product
   );

   modport slave (
      input  start, signed_mode, a, b,
      output busy, done, product
   );
endinterface

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier, one multiplier bit per clock.
// Signed operands are reduced to magnitudes at capture.
// The sign is re-applied to the final accumulator when the product is loaded.
// Latency is fixed at WIDTH cycles in CALC plus one DONE cycle.
module seq_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   seq_multiplier_if.slave bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e               state_q,   state_d;
   logic [2*WIDTH-1:0]   mcand_q,   mcand_d;    // multiplicand magnitude, pre-shifted
   logic [WIDTH-1:0]     mplier_q,  mplier_d;   // multiplier magnitude, consumed LSB first
   logic [2*WIDTH-1:0]   acc_q,     acc_d;
   logic [CW-1:0]        cnt_q,     cnt_d;
   logic                 neg_q,     neg_d;      // signed mode AND operand signs differ
   logic                 busy_q,    busy_d;
   logic                 done_q,    done_d;
   logic [2*WIDTH-1:0]   product_q, product_d;

   logic [2*WIDTH-1:0]   addend;
   logic [2*WIDTH-1:0]   acc_sum;

   // Magnitude of a possibly signed operand.
   // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sm);
      return (sm && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
   endfunction

   // Next-state and datapath: capture in IDLE, accumulate in CALC, one-cycle DONE.
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      product_d = product_q;

      addend  = mplier_q[0] ? mcand_q : '0;
      acc_sum = acc_q + addend;

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (bus.start) begin
               mcand_d  = {{WIDTH{1'b0}}, mag(bus.a, bus.signed_mode)};
               mplier_d = mag(bus.b, bus.signed_mode);
               neg_d    = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
               acc_d    = '0;
               cnt_d    = '0;
               busy_d   = 1'b1;
               state_d  = CALC;
            end
         end
         CALC: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               // Last bit: the sum already contains every partial product.
               product_d = neg_q ? (~acc_sum + (2*WIDTH)'(1)) : acc_sum;
               cnt_d     = '0;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               state_d   = DONE;
            end
         end
         DONE: begin
            // Start requests here are dropped, not queued.
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs; reset clears everything including the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         neg_q     <= neg_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         product_q <= product_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier at WIDTH=8.
// Directed corner cases and random operations are checked against an
// arithmetic reference model.
module tb_seq_multiplier;

   localparam int W = 8;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_errs   = 0;

   seq_multiplier_if #(.WIDTH(W)) bus ();

   seq_multiplier #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer multiply, with operands read as signed or unsigned.
   function automatic logic [2*W-1:0] ref_mul(input bit sm, input logic [W-1:0] x, input logic [W-1:0] y);
      longint px, py;
      px = longint'(x);
      py = longint'(y);
      if (sm && x[W-1]) px = px - (longint'(1) << W);
      if (sm && y[W-1]) py = py - (longint'(1) << W);
      return (2*W)'(px * py);
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Issue one operation from a negedge in IDLE.
   // Return at the negedge of the following IDLE cycle.
   // With poke set, start is re-pulsed mid-CALC and again in DONE.
   task automatic run_op(input bit sm, input logic [W-1:0] x, input logic [W-1:0] y, input bit poke);
      logic [2*W-1:0] exp;
      int dones;
      exp   = ref_mul(sm, x, y);
      dones = 0;
      bus.start       = 1'b1;
      bus.signed_mode = sm;
      bus.a           = x;
      bus.b           = y;
      tick();
      // Operands may change freely once captured.
      bus.start       = 1'b0;
      bus.a           = W'($urandom);
      bus.b           = W'($urandom);
      bus.signed_mode = 1'($urandom);
      for (int i = 0; i < W; i++) begin
         chk("busy_calc", 32'(bus.busy), 32'd1);
         dones += int'(bus.done);
         if (poke && i == 3) begin
            bus.start = 1'b1;
            bus.a     = W'(1);
            bus.b     = W'(1);
         end else begin
            bus.start = 1'b0;
         end
         tick();
      end
      chk("done_pulse", 32'(bus.done), 32'd1);
      chk("busy_done", 32'(bus.busy), 32'd0);
      chk("product", 32'(bus.product), 32'(exp));
      dones += int'(bus.done);
      if (poke) bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("done_clear", 32'(bus.done), 32'd0);
      chk("product_hold", 32'(bus.product), 32'(exp));
      if (poke) begin
         for (int i = 0; i < W + 2; i++) begin
            dones += int'(bus.done);
            chk("busy_idle", 32'(bus.busy), 32'd0);
            tick();
         end
         chk("done_count", 32'(dones), 32'd1);
      end
   endtask

   initial begin
      int seen;
      clk             = 1'b0;
      rst_n           = 1'b0;
      bus.start       = 1'b0;
      bus.signed_mode = 1'b0;
      bus.a           = '0;
      bus.b           = '0;
      #3;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_product", 32'(bus.product), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases
      run_op(1'b0, 8'h43, 8'h35, 1'b0);
      chk("dir_43x35", 32'(bus.product), 32'h0DDF);
      run_op(1'b0, 8'hFF, 8'h0F, 1'b0);
      chk("dir_u_ffx0f", 32'(bus.product), 32'h0EF1);
      run_op(1'b1, 8'hFF, 8'h0F, 1'b0);
      chk("dir_s_ffx0f", 32'(bus.product), 32'hFFF1);
      run_op(1'b1, 8'h80, 8'h80, 1'b0);
      chk("dir_s_80x80", 32'(bus.product), 32'h4000);
      run_op(1'b1, 8'h80, 8'h7F, 1'b0);
      chk("dir_s_80x7f", 32'(bus.product), 32'hC080);
      run_op(1'b0, 8'h00, 8'h00, 1'b0);
      chk("dir_zero", 32'(bus.product), 32'h0000);
      run_op(1'b0, 8'h43, 8'h35, 1'b1);
      chk("dir_ignore", 32'(bus.product), 32'h0DDF);

      // Reset asserted between edges during CALC cycle 4
      bus.start       = 1'b1;
      bus.signed_mode = 1'b0;
      bus.a           = 8'h43;
      bus.b           = 8'h35;
      tick();
      bus.start = 1'b0;
      repeat (3) tick();
      chk("pre_rst_busy", 32'(bus.busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(bus.busy), 32'd0);
      chk("arst_done", 32'(bus.done), 32'd0);
      chk("arst_product", 32'(bus.product), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 0;
      for (int i = 0; i < W + 4; i++) begin
         seen += int'(bus.done) + int'(bus.busy);
         tick();
      end
      chk("no_done_after_rst", 32'(seen), 32'd0);
      chk("product_after_rst", 32'(bus.product), 32'd0);
      run_op(1'b0, 8'h43, 8'h35, 1'b0);

      // Random back-to-back operations
      for (int n = 0; n < 40; n++) begin
         run_op(1'($urandom), W'($urandom), W'($urandom), 1'b0);
      end
      // Random corners at operand extremes
      for (int n = 0; n < 16; n++) begin
         logic [W-1:0] xa, xb;
         xa = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'hFF;
         xb = ($urandom_range(0, 1) == 1) ? 8'h7F : W'($urandom);
         run_op(1'($urandom), xa, xb, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1);
   end

endmodule
